// File: rtl/read_fwft_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | read_fwft_if : read-side bus of the FWFT output stage (empty flag, RAM     |
// |                port, consumer stream). Optional READ_FWFT_STATS_EN count.  |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
interface read_fwft_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  flag_empty;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
`ifdef READ_FWFT_STATS_EN
  logic [15:0]           rd_word_cnt;
`endif

  // master: the FWFT stage itself; slave: the surrounding FIFO and consumer
  modport master (
    input  flag_empty,
    input  mem_rdata,
    input  dout_ready,
    output r_en,
    output dout,
`ifdef READ_FWFT_STATS_EN
    output rd_word_cnt,
`endif
    output dout_valid
  );

  modport slave (
    output flag_empty,
    output mem_rdata,
    output dout_ready,
    input  r_en,
    input  dout,
`ifdef READ_FWFT_STATS_EN
    input  rd_word_cnt,
`endif
    input  dout_valid
  );
endinterface
`default_nettype wire

// File: rtl/read_fwft.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | read_fwft : first-word-fall-through stage with 2-entry skid buffer behind  |
// |             a 1-cycle-latency RAM read. Option READ_FWFT_STATS_EN adds a   |
// |             saturating delivered-word counter.                             |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module read_fwft #(
  parameter int DATA_WIDTH = 8
) (
  input  logic         r_clk,
  input  logic         r_rst,
  read_fwft_if.master  bus
);

  logic [DATA_WIDTH-1:0] r_slot0;
  logic [DATA_WIDTH-1:0] r_slot1;
  logic                  r_slot0_v;
  logic                  r_slot1_v;
  logic                  r_inflight;

  logic                  w_pop;
  logic                  w_issue;
  logic [2:0]            w_pending;

  assign w_pop = r_slot0_v & bus.dout_ready;

  // Words already owned after this cycle: buffered + inflight - leaving now.
  // Issuing only when that is <= 1 keeps buffered words at most 2.
  assign w_pending = {2'b00, r_slot0_v} + {2'b00, r_slot1_v}
                   + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue   = !r_rst && !bus.flag_empty && (w_pending <= 3'd1);

  assign bus.r_en       = w_issue;
  assign bus.dout       = r_slot0;
  assign bus.dout_valid = r_slot0_v;

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_slot0    <= '0;
      r_slot1    <= '0;
      r_slot0_v  <= 1'b0;
      r_slot1_v  <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (!w_pop) begin
        if (r_inflight) begin
          if (!r_slot0_v) begin
            r_slot0   <= bus.mem_rdata;
            r_slot0_v <= 1'b1;
          end else begin
            r_slot1   <= bus.mem_rdata;
            r_slot1_v <= 1'b1;
          end
        end
      end else if (r_slot1_v) begin
        r_slot0   <= r_slot1;
        r_slot1_v <= r_inflight;
        if (r_inflight) begin
          r_slot1 <= bus.mem_rdata;
        end
      end else begin
        r_slot0_v <= r_inflight;
        if (r_inflight) begin
          r_slot0 <= bus.mem_rdata;
        end
      end
    end
  end

`ifdef READ_FWFT_STATS_EN
  logic [15:0] r_word_cnt;

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_word_cnt <= '0;
    end else if (w_pop && (r_word_cnt != 16'hFFFF)) begin
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

  assign bus.rd_word_cnt = r_word_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_read_fwft.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_read_fwft : randomized bench for read_fwft against a queue-based model  |
// |                of issued-but-undelivered words.                            |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module tb_read_fwft;
  localparam int DW = 8;

  logic r_clk = 1'b0;
  logic r_rst;

  read_fwft_if #(.DATA_WIDTH(DW)) bus ();
  read_fwft #(.DATA_WIDTH(DW)) dut (.r_clk(r_clk), .r_rst(r_rst), .bus(bus));

  always #5 r_clk = ~r_clk;

  int vectors     = 0;
  int miscompares = 0;
  int delivered   = 0;

  logic [DW-1:0] src_q[$];   // words the upstream FIFO still holds
  logic [DW-1:0] exp_q[$];   // issued, not yet delivered, in issue order
  logic          last_ren = 1'b0;

  typedef struct {
    logic          rv, dv, fe;
    logic [DW-1:0] d;
    logic          exp_rv, exp_dv;
    logic [DW-1:0] exp_d;
    int            occ;
  } samp_t;

  // One clock: drive inputs, sample at negedge, derive expectations, advance model.
  task automatic cycle(input bit hold_empty, input bit rdy, output samp_t s);
    int occ; bit pop; int lr; logic [DW-1:0] w;
    bus.flag_empty = hold_empty || (src_q.size() == 0);
    bus.dout_ready = rdy;
    @(negedge r_clk);
    s.rv = bus.r_en; s.dv = bus.dout_valid; s.d = bus.dout; s.fe = bus.flag_empty;
    lr  = last_ren ? 1 : 0;
    occ = exp_q.size() - lr;
    pop = (occ > 0) && rdy;
    s.occ    = occ;
    s.exp_dv = (occ > 0);
    s.exp_d  = (occ > 0) ? exp_q[0] : '0;
    s.exp_rv = !s.fe && ((occ + lr - (pop ? 1 : 0)) <= 1);
    @(posedge r_clk); #1;
    if (pop) begin
      void'(exp_q.pop_front());
      delivered++;
    end
    if (s.rv) begin
      w = (src_q.size() > 0) ? src_q.pop_front() : DW'($urandom);
      exp_q.push_back(w);
      bus.mem_rdata = w;
    end else begin
      bus.mem_rdata = DW'($urandom);
    end
    last_ren = s.rv;
  endtask

  task automatic do_reset();
    r_rst = 1'b1;
    bus.flag_empty = 1'b1;
    bus.dout_ready = 1'b0;
    src_q.delete(); exp_q.delete();
    last_ren = 1'b0; delivered = 0;
    repeat (2) @(posedge r_clk);
    @(negedge r_clk); r_rst = 1'b0;
    @(posedge r_clk); #1;
  endtask

  task automatic test_reset();
    samp_t s;
    vectors++; if (bus.dout_valid !== 1'b0 || bus.dout !== '0 || bus.r_en !== 1'b0) begin
      miscompares++; $display("FAIL reset_poweron dv=%b dout=%h ren=%b want 0/00/0", bus.dout_valid, bus.dout, bus.r_en); end
    for (int i = 0; i < 8; i++) src_q.push_back(DW'(8'h10 + i));
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 1'b1, s);
      vectors++; if (s.rv !== s.exp_rv || s.dv !== s.exp_dv) begin
        miscompares++; $display("FAIL reset_prime c=%0d ren=%b/%b dv=%b/%b", c, s.rv, s.exp_rv, s.dv, s.exp_dv); end
    end
    bus.flag_empty = 1'b0; bus.dout_ready = 1'b1;
    #2;
    vectors++; if (bus.r_en !== 1'b1 || bus.dout_valid !== 1'b1) begin
      miscompares++; $display("FAIL reset_busy ren=%b dv=%b want 1/1", bus.r_en, bus.dout_valid); end
    r_rst = 1'b1;
    #1;
    vectors++; if (bus.dout_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_async_dv got=%b want 0", bus.dout_valid); end
    vectors++; if (bus.dout !== '0) begin
      miscompares++; $display("FAIL reset_async_dout got=%h want 00", bus.dout); end
    vectors++; if (bus.r_en !== 1'b0) begin
      miscompares++; $display("FAIL reset_async_ren got=%b want 0", bus.r_en); end
    src_q.delete(); exp_q.delete(); last_ren = 1'b0; delivered = 0;
    bus.flag_empty = 1'b1;
    repeat (2) @(posedge r_clk);
    @(negedge r_clk); r_rst = 1'b0;
    @(posedge r_clk); #1;
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, 1'b1, s);
      vectors++; if (s.rv !== 1'b0 || s.dv !== 1'b0) begin
        miscompares++; $display("FAIL reset_release c=%0d ren=%b dv=%b want 0/0", c, s.rv, s.dv); end
    end
  endtask

  task automatic test_fill_latency();
    samp_t s;
    src_q.push_back(8'hA5);
    cycle(1'b0, 1'b0, s);
    vectors++; if (s.rv !== 1'b1 || s.dv !== 1'b0) begin
      miscompares++; $display("FAIL fill_n ren=%b dv=%b want 1/0", s.rv, s.dv); end
    cycle(1'b0, 1'b0, s);
    vectors++; if (s.rv !== 1'b0 || s.dv !== 1'b0) begin
      miscompares++; $display("FAIL fill_n1 ren=%b dv=%b want 0/0", s.rv, s.dv); end
    cycle(1'b0, 1'b1, s);
    vectors++; if (s.dv !== 1'b1 || s.d !== 8'hA5) begin
      miscompares++; $display("FAIL fill_n2 dv=%b dout=%h want 1/a5", s.dv, s.d); end
    cycle(1'b0, 1'b0, s);
    vectors++; if (s.dv !== 1'b0) begin
      miscompares++; $display("FAIL fill_drain dv=%b want 0", s.dv); end
  endtask

  task automatic test_streaming();
    samp_t s;
    for (int i = 0; i < 16; i++) src_q.push_back(DW'(i));
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0, 1'b1, s);
      if (c < 16) begin
        vectors++; if (s.rv !== 1'b1) begin
          miscompares++; $display("FAIL stream_ren c=%0d got=%b want 1", c, s.rv); end
      end
      if (c >= 2 && c < 18) begin
        vectors++; if (s.dv !== 1'b1 || s.d !== DW'(c - 2)) begin
          miscompares++; $display("FAIL stream_dout c=%0d dv=%b dout=%h want 1/%h", c, s.dv, s.d, DW'(c - 2)); end
      end
    end
  endtask

  task automatic test_backpressure();
    samp_t s;
    int pulses = 0;
    for (int i = 0; i < 5; i++) src_q.push_back(DW'(i));
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 1'b0, s);
      pulses += s.rv ? 1 : 0;
    end
    vectors++; if (pulses != 2) begin
      miscompares++; $display("FAIL bp_pulses got=%0d want 2", pulses); end
    vectors++; if (s.dv !== 1'b1 || s.d !== '0) begin
      miscompares++; $display("FAIL bp_hold dv=%b dout=%h want 1/00", s.dv, s.d); end
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0, 1'b1, s);
      if (c < 5) begin
        vectors++; if (s.dv !== 1'b1 || s.d !== DW'(c)) begin
          miscompares++; $display("FAIL bp_release c=%0d dv=%b dout=%h want 1/%h", c, s.dv, s.d, DW'(c)); end
      end
    end
  endtask

  task automatic test_random();
    samp_t s;
    int start = delivered;
    int cyc   = 0;
    for (int i = 0; i < 200; i++) src_q.push_back(DW'($urandom));
    while ((delivered - start) < 200 && cyc < 3000) begin
      cycle(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, s);
      cyc++;
      vectors++; if (s.rv !== s.exp_rv) begin
        miscompares++; $display("FAIL rnd_ren cyc=%0d got=%b want=%b", cyc, s.rv, s.exp_rv); end
      vectors++; if (s.dv !== s.exp_dv || (s.exp_dv && s.d !== s.exp_d)) begin
        miscompares++; $display("FAIL rnd_dout cyc=%0d dv=%b dout=%h want %b/%h", cyc, s.dv, s.d, s.exp_dv, s.exp_d); end
      vectors++; if ((s.rv && s.fe) || s.occ > 2) begin
        miscompares++; $display("FAIL rnd_bounds cyc=%0d ren=%b empty=%b occ=%0d want no-ren-when-empty, occ<=2", cyc, s.rv, s.fe, s.occ); end
    end
    vectors++; if ((delivered - start) != 200) begin
      miscompares++; $display("FAIL rnd_count got=%0d want 200", delivered - start); end
  endtask

`ifdef READ_FWFT_STATS_EN
  task automatic test_stats();
    samp_t s;
    int cyc = 0;
    bit mid_checked = 1'b0;
    do_reset();
    vectors++; if (bus.rd_word_cnt !== 16'd0) begin
      miscompares++; $display("FAIL stats_reset0 got=%h want 0000", bus.rd_word_cnt); end
    while (delivered < 70000 && cyc < 71000) begin
      while (src_q.size() < 4) src_q.push_back(DW'($urandom));
      if (!mid_checked && delivered >= 40000) begin
        mid_checked = 1'b1;
        vectors++; if (bus.rd_word_cnt !== 16'(delivered)) begin
          miscompares++; $display("FAIL stats_mid got=%h want %h", bus.rd_word_cnt, 16'(delivered)); end
      end
      cycle(1'b0, 1'b1, s);
      cyc++;
    end
    vectors++; if (delivered < 70000 || bus.rd_word_cnt !== 16'hFFFF) begin
      miscompares++; $display("FAIL stats_sat got=%h delivered=%0d want ffff", bus.rd_word_cnt, delivered); end
    do_reset();
    vectors++; if (bus.rd_word_cnt !== 16'd0) begin
      miscompares++; $display("FAIL stats_clear got=%h want 0000", bus.rd_word_cnt); end
  endtask
`endif

  initial begin
    r_rst = 1'b1;
    bus.flag_empty = 1'b1;
    bus.dout_ready = 1'b0;
    bus.mem_rdata  = '0;
    do_reset();
    test_reset();
    test_fill_latency();
    test_streaming();
    test_backpressure();
    test_random();
`ifdef READ_FWFT_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
